// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes,
// state codes, ALU/mux select values and the packed control word.
package mips_ctrl_pkg;

    // Instr[31:26] opcodes understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // Codes 12..15 are unused and fall back to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ANDIEX = 4'd10,
        S_ANDIWB = 4'd11
    } state_t;

    // ALUOp into the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ANDI  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath enable and select driven by the controller
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational decode of the current FSM state into the control word.
// i_ready is the effective memory-ready used to qualify the fetch loads.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_ready,
    output ctrl_t  o_ctrl
);

    // Start from all-zero and raise only what each state needs
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.pc_write  = i_ready;
                o_ctrl.ir_write  = i_ready;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            S_ANDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ANDI;
            end
            S_ANDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Holds the state register,
// next-state logic and the sticky bad-opcode flag; control outputs come from
// the state decoder.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit HANDSHAKE_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_source,
    output logic [1:0] o_alu_op,
    output logic       o_bad_op,
    output logic [3:0] o_state
);

    state_t r_state;
    state_t w_state_next;
    logic   r_bad_op;
    logic   w_bad_op_set;
    logic   w_ready;
    ctrl_t  w_ctrl;

    // Zero is consumed by the datapath (PCWriteCond AND Zero), not here
    logic   w_unused;
    assign w_unused = i_zero;

    // Without the handshake the memory always completes in one cycle
    assign w_ready = HANDSHAKE_EN ? i_mem_ready : 1'b1;

    // State register, asynchronously forced to FETCH
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_FETCH;
        else         r_state <= w_state_next;
    end

    // Sticky flag for an opcode the controller cannot execute
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)           r_bad_op <= 1'b0;
        else if (w_bad_op_set) r_bad_op <= 1'b1;
    end

    // Next-state sequencing; Op is only looked at in DECODE and MEMADR
    always_comb begin
        w_state_next = r_state;
        w_bad_op_set = 1'b0;
        case (r_state)
            S_FETCH:  if (w_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_EXEC;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ANDI:      w_state_next = S_ANDIEX;
                    default: begin
                        w_state_next = S_FETCH;
                        w_bad_op_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                // Op can only be lw/sw here; anything else restarts fetch
                if (i_op == OP_LW)      w_state_next = S_MEMRD;
                else if (i_op == OP_SW) w_state_next = S_MEMWR;
                else                    w_state_next = S_FETCH;
            end
            S_MEMRD:  if (w_ready) w_state_next = S_MEMWB;
            S_MEMWB:  w_state_next = S_FETCH;
            S_MEMWR:  if (w_ready) w_state_next = S_FETCH;
            S_EXEC:   w_state_next = S_RWB;
            S_RWB:    w_state_next = S_FETCH;
            S_BEQ:    w_state_next = S_FETCH;
            S_JUMP:   w_state_next = S_FETCH;
            S_ANDIEX: w_state_next = S_ANDIWB;
            S_ANDIWB: w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .i_state (r_state),
        .i_ready (w_ready),
        .o_ctrl  (w_ctrl)
    );

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_pc_write_cond = w_ctrl.pc_write_cond;
    assign o_iord          = w_ctrl.iord;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_ir_write      = w_ctrl.ir_write;
    assign o_mem_to_reg    = w_ctrl.mem_to_reg;
    assign o_reg_dst       = w_ctrl.reg_dst;
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_alu_src_a     = w_ctrl.alu_src_a;
    assign o_alu_src_b     = w_ctrl.alu_src_b;
    assign o_pc_source     = w_ctrl.pc_source;
    assign o_alu_op        = w_ctrl.alu_op;
    assign o_bad_op        = r_bad_op;
    assign o_state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM: walks each instruction
// class cycle by cycle, checking the state and the full control word.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, rst_nh;
    logic [5:0] op, op_nh;
    logic       zero, mem_ready;
    logic       mem_ready_nh;

    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, bad;
    logic [1:0] srcb, pcs, aluop;
    logic [3:0] st;

    logic       pcw_n, pcwc_n, iord_n, mrd_n, mwr_n, irw_n, m2r_n, rdst_n, rw_n, srca_n, bad_n;
    logic [1:0] srcb_n, pcs_n, aluop_n;
    logic [3:0] st_n;

    logic [15:0] ctrl_a, ctrl_n;
    assign ctrl_a = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aluop};
    assign ctrl_n = {pcw_n, pcwc_n, iord_n, mrd_n, mwr_n, irw_n, m2r_n, rdst_n, rw_n, srca_n,
                     srcb_n, pcs_n, aluop_n};

    int  n_checks = 0;
    int  n_errors = 0;
    logic exp_bad = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.HANDSHAKE_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(pcw), .o_pc_write_cond(pcwc), .o_iord(iord), .o_mem_read(mrd),
        .o_mem_write(mwr), .o_ir_write(irw), .o_mem_to_reg(m2r), .o_reg_dst(rdst),
        .o_reg_write(rw), .o_alu_src_a(srca), .o_alu_src_b(srcb), .o_pc_source(pcs),
        .o_alu_op(aluop), .o_bad_op(bad), .o_state(st)
    );

    mips_multicycle_ctrl #(.HANDSHAKE_EN(1'b0)) dut_nh (
        .i_clk(clk), .i_reset(rst_nh), .i_op(op_nh), .i_zero(zero), .i_mem_ready(mem_ready_nh),
        .o_pc_write(pcw_n), .o_pc_write_cond(pcwc_n), .o_iord(iord_n), .o_mem_read(mrd_n),
        .o_mem_write(mwr_n), .o_ir_write(irw_n), .o_mem_to_reg(m2r_n), .o_reg_dst(rdst_n),
        .o_reg_write(rw_n), .o_alu_src_a(srca_n), .o_alu_src_b(srcb_n), .o_pc_source(pcs_n),
        .o_alu_op(aluop_n), .o_bad_op(bad_n), .o_state(st_n)
    );

    // Hand-written control word per state, field order:
    // pcw pcwc iord mrd mwr irw m2r rdst rw srca | srcb | pcs | aluop
    function automatic logic [15:0] ref_ctrl(input int s, input logic rdy);
        case (s)
            0:  return {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00};
            1:  return {10'b0, 2'b11, 2'b00, 2'b00};
            2:  return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  return {2'b00, 1'b1, 1'b1, 12'b0};
            4:  return {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
            5:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
            6:  return {9'b0, 1'b1, 2'b00, 2'b00, 2'b10};
            7:  return {7'b0, 1'b1, 1'b1, 7'b0};
            8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:  return {1'b1, 9'b0, 2'b00, 2'b10, 2'b00};
            10: return {9'b0, 1'b1, 2'b10, 2'b00, 2'b11};
            11: return {8'b0, 1'b1, 7'b0};
            default: return 16'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock cycle of the handshake DUT: drive ready, check, advance
    task automatic cyc(input string tag, input int s, input logic rdy);
        mem_ready = rdy;
        #1;
        chk($sformatf("%s st%0d state", tag, s), {28'b0, st}, s);
        chk($sformatf("%s st%0d ctrl", tag, s), {16'b0, ctrl_a}, {16'b0, ref_ctrl(s, rdy)});
        chk($sformatf("%s st%0d badop", tag, s), {31'b0, bad}, {31'b0, exp_bad});
        @(negedge clk);
    endtask

    // One clock cycle of the no-handshake DUT (effective ready is always 1)
    task automatic cyc_nh(input string tag, input int s);
        #1;
        chk($sformatf("%s st%0d state", tag, s), {28'b0, st_n}, s);
        chk($sformatf("%s st%0d ctrl", tag, s), {16'b0, ctrl_n}, {16'b0, ref_ctrl(s, 1'b1)});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rst_nh = 1'b1;
        op = LW; op_nh = LW;
        zero = 1'b0; mem_ready = 1'b1; mem_ready_nh = 1'b0;

        // Reset state
        #1;
        chk("reset state", {28'b0, st}, 0);
        chk("reset badop", {31'b0, bad}, 0);
        chk("reset ctrl", {16'b0, ctrl_a}, {16'b0, ref_ctrl(0, 1'b1)});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // lw; Op changed after MEMADR must not matter
        op = LW;
        cyc("lw", 0, 1); cyc("lw", 1, 1); cyc("lw", 2, 1);
        op = RT;
        cyc("lw", 3, 1); cyc("lw", 4, 1);
        $display("txn lw done");

        // R-type
        op = RT;
        cyc("rt", 0, 1); cyc("rt", 1, 1); cyc("rt", 6, 1); cyc("rt", 7, 1);
        $display("txn rtype done");

        // sw with three stall cycles in MEMWR
        op = SW;
        cyc("sw", 0, 1); cyc("sw", 1, 1); cyc("sw", 2, 1);
        cyc("sw", 5, 0); cyc("sw", 5, 0); cyc("sw", 5, 0); cyc("sw", 5, 1);
        $display("txn sw stalled done");

        // beq
        op = BEQ; zero = 1'b1;
        cyc("beq", 0, 1); cyc("beq", 1, 1); cyc("beq", 8, 1);
        zero = 1'b0;
        $display("txn beq done");

        // j
        op = JMP;
        cyc("j", 0, 1); cyc("j", 1, 1); cyc("j", 9, 1);
        $display("txn j done");

        // fetch stall then unsupported opcode
        op = BAD;
        cyc("bad", 0, 0); cyc("bad", 0, 1); cyc("bad", 1, 1);
        exp_bad = 1'b1;
        $display("txn badop done");

        // andi, BadOp must persist
        op = ANDI;
        cyc("andi", 0, 1); cyc("andi", 1, 1); cyc("andi", 10, 1); cyc("andi", 11, 1);
        $display("txn andi done");

        // lw interrupted by an unaligned reset pulse while waiting in MEMRD
        op = LW;
        cyc("lwrst", 0, 1); cyc("lwrst", 1, 1); cyc("lwrst", 2, 1); cyc("lwrst", 3, 0);
        mem_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async rst state", {28'b0, st}, 0);
        chk("async rst badop", {31'b0, bad}, 0);
        chk("async rst ctrl", {16'b0, ctrl_a}, {16'b0, ref_ctrl(0, 1'b0)});
        exp_bad = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("post rst state", {28'b0, st}, 0);
        @(negedge clk);
        cyc("lwrst", 0, 1); cyc("lwrst", 1, 1);
        $display("txn reset mid-memrd done");

        // No handshake, MemReady tied low: lw still takes 5 cycles
        rst_nh = 1'b0;
        cyc_nh("nh", 0); cyc_nh("nh", 1); cyc_nh("nh", 2);
        cyc_nh("nh", 3); cyc_nh("nh", 4); cyc_nh("nh", 0);
        $display("txn lw no-handshake done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle variant of our MIPS datapath; sits directly upstream of the ALU control decoder.
- It drives ALUOp (2 bits) into the ALU control decoder, and the datapath routes Instr[5:0] to that decoder's Funct input.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Generates every datapath enable and mux select, and stalls on a memory-ready handshake.

Parameters:
- HANDSHAKE_EN, 1, when 0 MemReady is ignored and treated as constant 1 (single-cycle memory).

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; forces state to FETCH and clears BadOp
- Op  input  6  Instr[31:26] from the instruction register
- Zero  input  1  ALU zero flag (used in BEQ state only)
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by Zero (datapath ANDs)
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  1 = MDR to register file write data
- RegDst  output  1  1 = rd, 0 = rt
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = A register
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  output  2  00 = add, 01 = sub, 10 = decode Funct, 11 = and-immediate
- BadOp  output  1  sticky: an unsupported opcode was decoded
- State  output  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ANDIEX=10, ANDIWB=11. Codes 12–15 are unused and go to FETCH next cycle.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, andi=001100.
- All outputs are decoded combinationally from the current state, with MemReady qualification where noted. Any output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - PCWrite and IRWrite equal the effective ready (MemReady, or 1 when HANDSHAKE_EN=0).
  - Advances to DECODE when ready; otherwise holds.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target into ALUOut).
  - Next state: lw/sw→MEMADR, R→EXEC, beq→BEQ, j→JUMP, andi→ANDIEX.
  - Any other Op→FETCH, with BadOp set at that edge.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw→MEMRD, sw→MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH. Zero is consumed by the datapath, not by the FSM.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11 → ANDIWB.
- ANDIWB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- Instruction latencies with a ready memory: lw 5 cycles, sw/R/andi 4, beq/j 3. Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Op is sampled only in DECODE and MEMADR; Op changes in other states have no effect.
- Reset asserted at any time, including mid-wait in MEMWR:
  - State goes to FETCH immediately (asynchronously).
  - BadOp clears to 0.
  - The outputs show FETCH values while Reset is held: MemRead=1, ALUSrcB=01, ALUOp=00, and PCWrite/IRWrite equal to ready. The datapath must gate PC/IR with Reset.
- BadOp stays at 1 until Reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ANDI);
  - state encodings S_FETCH..S_ANDIWB;
  - ALUOp encodings ALUOP_ADD/SUB/FUNCT/ANDI;
  - ALUSrcB and PCSource encodings.
- One sub-module, mips_ctrl_outdec: pure combinational state→control-word decoder. The top keeps the state register, next-state logic and the BadOp flag.

Test Plan:
- lw (Op=100011), MemReady=1 throughout → states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in the state-4 cycle.
- R-type (Op=000000) → states 0,1,6,7,0. ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
- sw with MemReady=0 for 3 cycles in MEMWR → state 5 held 4 cycles with MemWrite=1, IorD=1, then FETCH. Exactly one write cycle has MemReady=1.
- beq → states 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. j → states 0,1,9,0 with PCWrite=1, PCSource=10.
- Op=111111 at DECODE → next state 0 and BadOp=1, which persists through a following andi (0,1,10 with ALUOp=11, then 11, 0).
- Reset pulse mid-MEMRD, not aligned to Clk → State=0 and BadOp=0 before the next edge. Same run with HANDSHAKE_EN=0 and MemReady tied to 0 → lw completes in 5 cycles.
